trace_dump: RTL and testbench
=============================

# trace_dump

Readout engine for the capture RAM. Once a capture completes, the command path issues a `dump` request. The block then reads all 512 samples out of the circular trace buffer, starting with the oldest sample (`trace_end + 1`) and ending with the newest (`trace_end`). It hands each sample, one byte at a time, to the UART transmitter, and releases the capture engine by pulsing `clr_cap_done`.

## Interface
Parameters:
- `DEPTH`, default 512. Trace buffer depth in samples. Must be a power of two matching the 9-bit address.

Ports:
- `clk` (in, 1): system clock, the same clock as the capture engine.
- `rst_n` (in, 1): asynchronous reset, active low.
- `dump` (in, 1): one-cycle start request. Honoured only in IDLE.
- `abort` (in, 1): stops a dump in progress and returns to IDLE.
- `trace_end` (in, 9): address of the newest sample, from the capture engine.
- `rdata` (in, 8): RAM read data, valid one cycle after `en`.
- `gain` (in, 8): correction gain. 0x80 is unity. Used only with `DUMP_CORRECT_EN`.
- `offset` (in, 8): signed correction offset. Used only with `DUMP_CORRECT_EN`.
- `tx_done` (in, 1): one-cycle pulse from the UART when a byte is finished.
- `en` (out, 1): RAM read enable. `we` to the RAM is tied 0 by this block's owner.
- `addr` (out, 9): RAM read address.
- `tx_data` (out, 8): byte presented to the UART.
- `trmt` (out, 1): one-cycle transmit strobe.
- `busy` (out, 1): high in every state except IDLE.
- `dump_done` (out, 1): one-cycle pulse after the 512th byte's `tx_done`.
- `clr_cap_done` (out, 1): one-cycle pulse, coincident with `dump_done`. Clears the capture-done bit in `trig_cfg`.

## Operation
- **Reset values:** every output is 0 (`en`, `addr`, `tx_data`, `trmt`, `busy`, `dump_done`, `clr_cap_done`), and the state is IDLE.
- **Internal registers:**
  - `rd_ptr`, 9 bits. Wraps 511 → 0.
  - `cnt`, 10 bits. Counts bytes already sent.
- **States and transitions:**
  - IDLE: on `dump`, load `rd_ptr` with `trace_end + 1` (9-bit wrap, so 511 → 0), clear `cnt`, go to READ. `tx_done` in IDLE is ignored.
  - READ: `en = 1`, `addr = rd_ptr`. Go to LATCH.
  - LATCH: register `tx_data` from `rdata` (corrected when enabled). Go to SEND.
  - SEND: `trmt = 1` for exactly one cycle. Go to WAIT.
  - WAIT: hold `tx_data` stable. On `tx_done`:
    - if `cnt == DEPTH-1`, go to DONE;
    - otherwise increment `rd_ptr` and `cnt`, then go to READ.
  - DONE: pulse `dump_done` and `clr_cap_done`, go to IDLE.
- **Sampling rules:**
  - `trace_end` is sampled only at the IDLE→READ transition. Later changes have no effect.
  - `dump` while `busy` is ignored; it is neither queued nor used to restart.
- **`abort`:**
  - In any non-IDLE state, `abort` forces IDLE on the next edge, and no `dump_done` or `clr_cap_done` is produced.
  - `abort` wins over a simultaneous `tx_done`.
  - If `abort` arrives in SEND, `trmt` has already been issued, so the UART finishes that byte on its own.
- **Address output:** `addr` is registered and holds its last value outside READ.

## Timing
- `dump` sampled at edge 0. Then:
  - `en` is high in cycle 1;
  - `tx_data` is valid from cycle 3;
  - `trmt` is high in cycle 3.
- Per-byte overhead: 3 cycles (READ, LATCH, SEND), plus the WAIT cycles until `tx_done`. A `tx_done` one cycle after `trmt` gives a minimum of 4 cycles per byte.
- `dump_done` follows the last `tx_done` by exactly 1 cycle, and `busy` drops on the same edge.
- Total bytes per dump: exactly 512. Wrap-around applies when `trace_end + 1 + n` exceeds 511.

## Configuration
- **`DUMP_CORRECT_EN` defined:**
  1. `sum = {2'b0, rdata} + sign-extended offset`, a 10-bit signed value.
  2. Clip `sum` to the range 0..255.
  3. `prod = clip * gain`, 16 bits.
  4. `tx_data = prod >> 7`, saturated to 255.
  - All of this is combinational into the LATCH register, so latency is unchanged.
- **Undefined:** `tx_data = rdata` unchanged. `gain` and `offset` are unused.

## Test plan
- **Ordering:**
  - Stimulus: RAM preloaded with `mem[i] = i[7:0]`, `trace_end = 100`, `dump`, UART model returning `tx_done` 2 cycles after `trmt`.
  - Required: 512 bytes in the order 101..255, 0..255, 0..100 (address sequence 101..511, then 0..100); `dump_done` and `clr_cap_done` high for exactly one cycle.
- **Wrap at boundary:**
  - Stimulus: `trace_end = 511`.
  - Required: first address is 0, last address is 511.
- **Start latency and stray inputs:**
  - Stimulus: `dump` at cycle 0.
  - Required: `en` at cycle 1, `trmt` at cycle 3. A second `dump` while `busy` is ignored, and `tx_done` pulses in IDLE produce no `trmt`.
- **Abort:**
  - Stimulus: `abort` during the 10th WAIT, coincident with `tx_done`.
  - Required: IDLE next cycle, `busy = 0`, no `dump_done` or `clr_cap_done`. A following `dump` restarts from `trace_end + 1`.
- **Correction (`DUMP_CORRECT_EN`):**

  | `rdata` | `offset` | `gain` | Required `tx_data` |
  |---|---|---|---|
  | 0x40 | 0x10 | 0x80 | 0x50 |
  | 0xF0 | 0x20 | 0x80 | 0xFF |
  | 0x10 | 0xE0 | 0x80 | 0x00 |
  | 0x90 | 0x00 | 0xFF | 0xFF |

- **Reset mid-dump:**
  - Stimulus: assert `rst_n` low during WAIT.
  - Required: all outputs 0 immediately (asynchronous), IDLE after release.

Source files
------------

// File: rtl/trace_dump_if.sv
// trace_dump_if: command, RAM-read and UART signals of the trace readout engine
interface trace_dump_if;
    logic       dump;
    logic       abort;
    logic [8:0] trace_end;
    logic [7:0] rdata;
    logic [7:0] gain;
    logic [7:0] offset;
    logic       tx_done;
    logic       en;
    logic [8:0] addr;
    logic [7:0] tx_data;
    logic       trmt;
    logic       busy;
    logic       dump_done;
    logic       clr_cap_done;

    modport master (
        output dump, abort, trace_end, rdata, gain, offset, tx_done,
        input  en, addr, tx_data, trmt, busy, dump_done, clr_cap_done
    );

    modport slave (
        input  dump, abort, trace_end, rdata, gain, offset, tx_done,
        output en, addr, tx_data, trmt, busy, dump_done, clr_cap_done
    );
endinterface

// File: rtl/trace_dump.sv
// trace_dump: reads the circular trace buffer oldest-first and streams it byte by byte to the UART.
// Define DUMP_CORRECT_EN to apply offset/gain correction to each sample on its way to the UART.
module trace_dump #(
    parameter int DEPTH = 512
) (
    input logic         clk,
    input logic         rst_n,
    trace_dump_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, WAIT, DONE} state_t;

    state_t     state;
    logic [8:0] rd_ptr;
    logic [9:0] cnt;
    logic [7:0] corr;

`ifdef DUMP_CORRECT_EN
    logic signed [9:0] sum;
    logic [7:0]        clip;
    logic [15:0]       prod;

    // offset, clip to a byte, apply gain (0x80 = unity), saturate
    always_comb begin
        sum  = $signed({2'b0, bus.rdata}) + $signed({{2{bus.offset[7]}}, bus.offset});
        clip = (sum < 10'sd0) ? 8'd0 : ((sum > 10'sd255) ? 8'hff : sum[7:0]);
        prod = {8'd0, clip} * {8'd0, bus.gain};
        corr = prod[15] ? 8'hff : prod[14:7];
    end
`else
    assign corr = bus.rdata;
`endif

    // readout sequencer; every output is registered, abort overrides any in-flight state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            rd_ptr           <= '0;
            cnt              <= '0;
            bus.en           <= 1'b0;
            bus.addr         <= '0;
            bus.tx_data      <= '0;
            bus.trmt         <= 1'b0;
            bus.busy         <= 1'b0;
            bus.dump_done    <= 1'b0;
            bus.clr_cap_done <= 1'b0;
        end else if (bus.abort && state != IDLE) begin
            state            <= IDLE;
            bus.en           <= 1'b0;
            bus.trmt         <= 1'b0;
            bus.busy         <= 1'b0;
            bus.dump_done    <= 1'b0;
            bus.clr_cap_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.dump) begin
                    rd_ptr   <= bus.trace_end + 9'd1;
                    bus.addr <= bus.trace_end + 9'd1;
                    cnt      <= '0;
                    bus.en   <= 1'b1;
                    bus.busy <= 1'b1;
                    state    <= READ;
                end
                READ: begin
                    bus.en <= 1'b0;
                    state  <= LATCH;
                end
                LATCH: begin
                    bus.tx_data <= corr;
                    bus.trmt    <= 1'b1;
                    state       <= SEND;
                end
                SEND: begin
                    bus.trmt <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: if (bus.tx_done) begin
                    if (cnt == 10'(DEPTH - 1)) begin
                        bus.dump_done    <= 1'b1;
                        bus.clr_cap_done <= 1'b1;
                        state            <= DONE;
                    end else begin
                        rd_ptr   <= rd_ptr + 9'd1;
                        bus.addr <= rd_ptr + 9'd1;
                        cnt      <= cnt + 10'd1;
                        bus.en   <= 1'b1;
                        state    <= READ;
                    end
                end
                DONE: begin
                    bus.dump_done    <= 1'b0;
                    bus.clr_cap_done <= 1'b0;
                    bus.busy         <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trace_dump.sv
// tb_trace_dump: directed/random bench with RAM and UART models and a reference ordering model
module tb_trace_dump;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trace_dump_if bus();
    trace_dump #(.DEPTH(512)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [512];
    logic       uart_on = 1'b1;
    logic       man_td = 1'b0;
    logic       uart_td = 1'b0;
    logic       d0 = 1'b0;
    int         cyc = 0;
    int         last_td = 0;
    int         done_cyc = 0;
    int         done_n = 0;
    int         clr_n = 0;
    int         coinc_bad = 0;
    logic [7:0] got_b [$];
    logic [8:0] got_a [$];
    int         checks = 0;
    int         passes = 0;
    int         fails = 0;
    int         s_a, s_b, base_done, base_clr;

    assign bus.tx_done = uart_td | man_td;

    // synchronous-read RAM
    always @(posedge clk) if (bus.en) bus.rdata <= mem[bus.addr];

    // UART: finishes each byte two cycles after its trmt
    always @(posedge clk) begin
        d0      <= bus.trmt & uart_on;
        uart_td <= d0;
        cyc     <= cyc + 1;
    end

    // mid-cycle monitor of addresses, bytes and completion pulses
    always @(negedge clk) begin
        if (bus.tx_done) last_td <= cyc;
        if (bus.dump_done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (bus.clr_cap_done) clr_n <= clr_n + 1;
        if (bus.dump_done !== bus.clr_cap_done) coinc_bad <= coinc_bad + 1;
        if (bus.trmt) got_b.push_back(bus.tx_data);
        if (bus.en) got_a.push_back(bus.addr);
    end

    function automatic int model(int v);
`ifdef DUMP_CORRECT_EN
        int s, p;
        s = v + ((bus.offset >= 8'd128) ? int'(bus.offset) - 256 : int'(bus.offset));
        s = (s < 0) ? 0 : ((s > 255) ? 255 : s);
        p = (s * int'(bus.gain)) / 128;
        return (p > 255) ? 255 : p;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.en, bus.addr, bus.tx_data, bus.trmt, bus.busy, bus.dump_done, bus.clr_cap_done});
    endfunction

    task automatic launch(int te);
        bus.trace_end = te[8:0];
        s_a       = got_a.size();
        s_b       = got_b.size();
        base_done = done_n;
        base_clr  = clr_n;
        bus.dump  = 1'b1;
        tick();
        bus.dump  = 1'b0;
    endtask

    task automatic finish_dump(int te, string tag);
        int k = 0;
        int bad = -1;
        while (done_n == base_done && k < 6000) begin
            tick();
            k++;
        end
        check({tag, " timeout"}, int'(k < 6000), 1);
        tick();
        tick();
        check({tag, " nbytes"}, got_b.size() - s_b, 512);
        check({tag, " naddr"}, got_a.size() - s_a, 512);
        for (int n = 0; n < 512; n++) begin
            int a = (te + 1 + n) % 512;
            if (bad < 0 && (s_a + n >= got_a.size() || s_b + n >= got_b.size() ||
                            int'(got_a[s_a + n]) != a || int'(got_b[s_b + n]) != model(int'(mem[a]))))
                bad = n;
        end
        check({tag, " first bad index"}, bad, -1);
        check({tag, " done pulses"}, done_n - base_done, 1);
        check({tag, " clr pulses"}, clr_n - base_clr, 1);
        check({tag, " done/clr coincide"}, coinc_bad, 0);
        check({tag, " done latency"}, done_cyc - last_td, 1);
        check({tag, " busy after"}, int'(bus.busy), 0);
    endtask

    initial begin
        int te, seen, k;
        bus.dump = 1'b0;
        bus.abort = 1'b0;
        bus.trace_end = '0;
        bus.gain = 8'h80;
        bus.offset = 8'h00;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i);
        tick();
        tick();
        check("reset outputs", outs(), 0);
        rst_n = 1'b1;
        tick();

        launch(100);
        check("lat en c1", int'(bus.en), 1);
        check("lat busy c1", int'(bus.busy), 1);
        check("lat addr c1", int'(bus.addr), 101);
        check("lat trmt c1", int'(bus.trmt), 0);
        tick();
        check("lat en c2", int'(bus.en), 0);
        tick();
        check("lat trmt c3", int'(bus.trmt), 1);
        check("lat tx_data c3", int'(bus.tx_data), 101);
        bus.trace_end = 9'($urandom);
        bus.dump = 1'b1;
        tick();
        bus.dump = 1'b0;
        finish_dump(100, "order");

        launch(511);
        finish_dump(511, "wrap");
        check("wrap first addr", int'(got_a[s_a]), 0);
        check("wrap last addr", int'(got_a[s_a + 511]), 511);

        uart_on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            man_td = 1'b1;
            tick();
            man_td = 1'b0;
            check("idle tx_done trmt", int'(bus.trmt), 0);
            check("idle tx_done busy", int'(bus.busy), 0);
            tick();
        end
        uart_on = 1'b1;

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
            bus.gain = 8'($urandom);
            bus.offset = 8'($urandom);
            te = int'($urandom_range(0, 511));
            launch(te);
            finish_dump(te, "random");
        end

        te = int'($urandom_range(0, 511));
        launch(te);
        seen = 0;
        k = 0;
        while (seen < 10 && k < 200) begin
            tick();
            if (bus.trmt) seen++;
            k++;
        end
        check("abort reach 10th send", seen, 10);
        tick();
        tick();
        bus.abort = 1'b1;
        check("abort with tx_done", int'(bus.tx_done), 1);
        tick();
        bus.abort = 1'b0;
        check("abort busy", int'(bus.busy), 0);
        check("abort en", int'(bus.en), 0);
        for (int i = 0; i < 6; i++) tick();
        check("abort trmt", int'(bus.trmt), 0);
        check("abort no done", done_n - base_done, 0);
        check("abort no clr", clr_n - base_clr, 0);
        check("abort bytes sent", got_b.size() - s_b, 10);
        launch(te);
        finish_dump(te, "restart");
        check("restart first addr", int'(got_a[s_a]), (te + 1) % 512);

`ifdef DUMP_CORRECT_EN
        begin
            logic [31:0] rows [4];
            rows[0] = 32'h40_10_80_50;
            rows[1] = 32'hF0_20_80_FF;
            rows[2] = 32'h10_E0_80_00;
            rows[3] = 32'h90_00_FF_FF;
            for (int r = 0; r < 4; r++) begin
                for (int i = 0; i < 512; i++) mem[i] = rows[r][31:24];
                bus.offset = rows[r][23:16];
                bus.gain   = rows[r][15:8];
                launch(0);
                tick();
                tick();
                check("correct trmt", int'(bus.trmt), 1);
                check("correct tx_data", int'(bus.tx_data), int'(rows[r][7:0]));
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                tick();
            end
        end
`endif

        launch(int'($urandom_range(0, 511)));
        k = 0;
        while (!bus.trmt && k < 20) begin
            tick();
            k++;
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", outs(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("post reset busy", int'(bus.busy), 0);
        check("post reset trmt", int'(bus.trmt), 0);
        check("post reset en", int'(bus.en), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
